// File: rtl/imem_loader.sv
// Boot loader: frames a byte stream into little-endian words and writes
// them to instruction memory, holding the core in reset until a good load.
module imem_loader #(
   parameter int         DEPTH     = 256,
   parameter logic [7:0] SYNC_BYTE = 8'hA5,
   parameter bit         BOOT_HOLD = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        cpu_rst_n,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_DATA,
      S_WRITE,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  n_q, n_d;
   logic [8:0]  word_idx_q, word_idx_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [7:0]  acc_q, acc_d;
   logic [23:0] word_q, word_d;
   logic        rx_ready_q, rx_ready_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        cpu_rst_n_q, cpu_rst_n_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        error_q, error_d;

   logic       accept;
   logic [8:0] target;

   assign accept = rx_valid && rx_ready_q;
   // Word count runs to N (or DEPTH for N=0); only its low bits index memory.
   assign target = (n_q == 8'd0) ? 9'(DEPTH) : {1'b0, n_q};

   always_comb begin
      state_d     = state_q;
      n_d         = n_q;
      word_idx_d  = word_idx_q;
      byte_cnt_d  = byte_cnt_q;
      acc_d       = acc_q;
      word_d      = word_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cpu_rst_n_d = cpu_rst_n_q;
      done_d      = done_q;
      error_d     = error_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept && rx_data == SYNC_BYTE) state_d = S_LEN;
         end
         S_LEN: begin
            if (accept) begin
               n_d         = rx_data;
               word_idx_d  = 9'd0;
               byte_cnt_d  = 2'd0;
               acc_d       = 8'd0;
               cpu_rst_n_d = 1'b0;
               state_d     = S_DATA;
            end
         end
         S_DATA: begin
            if (accept) begin
               acc_d      = acc_q ^ rx_data;
               byte_cnt_d = byte_cnt_q + 2'd1;
               unique case (byte_cnt_q)
                  2'd0: word_d[7:0]   = rx_data;
                  2'd1: word_d[15:8]  = rx_data;
                  2'd2: word_d[23:16] = rx_data;
                  2'd3: begin
                     mem_we_d    = 1'b1;
                     mem_addr_d  = 32'({word_idx_q[AW-1:0], 2'b00});
                     mem_wdata_d = {rx_data, word_q};
                     state_d     = S_WRITE;
                  end
                  default: ;
               endcase
            end
         end
         S_WRITE: begin
            word_idx_d = word_idx_q + 9'd1;
            if (word_idx_q + 9'd1 == target) state_d = S_CSUM;
            else                              state_d = S_DATA;
         end
         S_CSUM: begin
            if (accept) begin
               if (rx_data == acc_q) begin
                  done_d      = 1'b1;
                  cpu_rst_n_d = 1'b1;
                  state_d     = S_DONE;
               end else begin
                  error_d     = 1'b1;
                  cpu_rst_n_d = 1'b0;
                  state_d     = S_ERR;
               end
            end
         end
         S_DONE, S_ERR: begin
            if (accept && rx_data == SYNC_BYTE) begin
               done_d  = 1'b0;
               error_d = 1'b0;
               state_d = S_LEN;
            end
         end
         default: state_d = S_IDLE;
      endcase
      rx_ready_d = (state_d != S_WRITE);
      busy_d     = (state_d == S_LEN)   || (state_d == S_DATA) ||
                   (state_d == S_WRITE) || (state_d == S_CSUM);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         n_q         <= 8'd0;
         word_idx_q  <= 9'd0;
         byte_cnt_q  <= 2'd0;
         acc_q       <= 8'd0;
         word_q      <= 24'd0;
         rx_ready_q  <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_wdata_q <= 32'd0;
         cpu_rst_n_q <= ~BOOT_HOLD;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         n_q         <= n_d;
         word_idx_q  <= word_idx_d;
         byte_cnt_q  <= byte_cnt_d;
         acc_q       <= acc_d;
         word_q      <= word_d;
         rx_ready_q  <= rx_ready_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_rst_n_q <= cpu_rst_n_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   assign rx_ready  = rx_ready_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign cpu_rst_n = cpu_rst_n_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign error     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: frames are built from a word list and
// the expected writes/status come from the frame rules directly.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        cpu_rst_n;
   logic        busy;
   logic        done;
   logic        error;

   int n_chk  = 0;
   int n_pass = 0;

   logic [31:0] words[$];
   logic [31:0] obs_addr[$];
   logic [31:0] obs_data[$];
   logic        exp_run;

   always #5 clk = ~clk;

   imem_loader dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_rst_n (cpu_rst_n),
      .busy      (busy),
      .done      (done),
      .error     (error)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   // A write strobe must never coincide with an open receive slot.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         obs_addr.push_back(mem_addr);
         obs_data.push_back(mem_wdata);
         check("ready_during_we", 32'(rx_ready), 32'd0);
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      t = 0;
      while (rx_ready !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) check("accept_timeout", 32'(t), 32'd0);
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic fill_words(input int n);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
   endtask

   task automatic run_frame(input int nfield, input bit bad, input int gmax);
      int nw;
      logic [7:0] cs;
      logic [31:0] w;
      nw = (nfield == 0) ? 256 : nfield;
      cs = 8'd0;
      obs_addr.delete();
      obs_data.delete();
      send_byte(8'hA5, $urandom_range(0, gmax));
      check("sync_cpu_rst", 32'(cpu_rst_n), 32'(exp_run));
      check("sync_done_clr", 32'(done), 32'd0);
      check("sync_err_clr", 32'(error), 32'd0);
      send_byte(8'(nfield), $urandom_range(0, gmax));
      check("len_cpu_rst", 32'(cpu_rst_n), 32'd0);
      check("len_busy", 32'(busy), 32'd1);
      for (int i = 0; i < nw; i++) begin
         w = words[i];
         for (int j = 0; j < 4; j++) begin
            cs ^= w[8*j +: 8];
            send_byte(w[8*j +: 8], $urandom_range(0, gmax));
         end
      end
      send_byte(bad ? (cs ^ 8'h01) : cs, $urandom_range(0, gmax));
      exp_run = !bad;
      check("done", 32'(done), 32'(!bad));
      check("error", 32'(error), 32'(bad));
      check("cpu_rst_n", 32'(cpu_rst_n), 32'(exp_run));
      check("busy_end", 32'(busy), 32'd0);
      check("n_writes", 32'(obs_addr.size()), 32'(nw));
      for (int i = 0; i < nw && i < obs_addr.size(); i++) begin
         check("wr_addr", obs_addr[i], 32'((i % 256) * 4));
         check("wr_data", obs_data[i], words[i]);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      exp_run  = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 32'(rx_ready), 32'd0);
      check("rst_we", 32'(mem_we), 32'd0);
      check("rst_addr", mem_addr, 32'd0);
      check("rst_wdata", mem_wdata, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_cpu", 32'(cpu_rst_n), 32'd1);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_rst", 32'(rx_ready), 32'd1);

      // Directed frame: two known instructions, good then bad then good.
      words.delete();
      words.push_back(32'h00A00093);
      words.push_back(32'h01400113);
      run_frame(2, 1'b0, 0);
      run_frame(2, 1'b1, 0);
      run_frame(2, 1'b0, 0);

      // Noise in idle-like states is ignored.
      obs_addr.delete();
      send_byte(8'h00, 0);
      send_byte(8'hFF, 1);
      send_byte(8'h5A, 0);
      repeat (3) @(negedge clk);
      check("noise_writes", 32'(obs_addr.size()), 32'd0);
      check("noise_busy", 32'(busy), 32'd0);
      check("noise_done", 32'(done), 32'd1);

      // Random frames with valid gaps, some with corrupted checksums.
      for (int k = 0; k < 6; k++) begin
         fill_words($urandom_range(1, 8));
         run_frame(words.size(), ($urandom_range(0, 2) == 0), 3);
      end

      // Full-depth frame via length 0.
      fill_words(256);
      run_frame(0, 1'b0, 0);
      check("last_addr", obs_addr.size() == 256 ? obs_addr[255] : 32'hX,
            32'h3FC);

      // Reset mid-word discards the partial word.
      obs_addr.delete();
      send_byte(8'hA5, 0);
      send_byte(8'h01, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("mrst_busy", 32'(busy), 32'd0);
      check("mrst_cpu", 32'(cpu_rst_n), 32'd1);
      check("mrst_ready", 32'(rx_ready), 32'd0);
      check("mrst_done", 32'(done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("mrst_writes", 32'(obs_addr.size()), 32'd0);
      exp_run = 1'b1;
      fill_words(1);
      run_frame(1, 1'b0, 2);

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes the instruction memory from a byte stream, typically fed by the UART receiver. It frames the stream, assembles little-endian 32-bit instruction words and drives the instruction memory write port with word-aligned byte addresses. While a load is in progress it holds the CPU core in reset, and it releases the core only after a checksum-verified load.

## Interface
- `DEPTH`, 256: instruction memory size in words. Must be a power of two, ≤ 256.
- `SYNC_BYTE`, 8'hA5: start-of-frame marker.
- `BOOT_HOLD`, 0: 1 means `cpu_rst_n` stays low after reset until the first successful load; 0 means the core runs from the preloaded image.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `rx_data`  in  8  incoming byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader accepts a byte; a transfer occurs when `rx_valid && rx_ready` at the rising edge.
- `mem_we`  out  1  one-cycle write strobe to the instruction memory.
- `mem_addr`  out  32  byte address, equal to `{word_idx, 2'b00}`; upper bits are 0.
- `mem_wdata`  out  32  instruction word.
- `cpu_rst_n`  out  1  active-low reset to the CPU core.
- `busy`  out  1  frame in progress (states LEN, DATA, WRITE, CSUM).
- `done`  out  1  last frame loaded with a good checksum.
- `error`  out  1  last frame failed its checksum.

## Operation
- Frame format: `SYNC_BYTE`, then a length byte `N` (number of words, 1..255; 0 means `DEPTH`), then 4·N data bytes (LSB first per word), then a checksum byte. The checksum is the XOR of all data bytes.
- IDLE: `rx_ready`=1. `SYNC_BYTE` moves to LEN. Any other byte is discarded.
- LEN: on accept:
  - latch `N`, clear `word_idx`, byte count and checksum accumulator;
  - drive `cpu_rst_n`=0;
  - go to DATA.
- DATA: on accept, place the byte into the word at lane `byte_cnt` and XOR it into the accumulator. On the 4th byte, go to WRITE. `SYNC_BYTE` inside DATA is ordinary data.
- WRITE: one cycle.
  - `rx_ready`=0, `mem_we`=1, with `mem_addr` and `mem_wdata` valid.
  - Then increment `word_idx`.
  - If `word_idx`+1 == `N` (mod `DEPTH` for N=0), go to CSUM; else go to DATA.
- CSUM: on accept, compare the byte with the accumulator.
  - Match: go to DONE.
  - Mismatch: go to ERR.
- DONE: `done`=1, `cpu_rst_n`=1.
- ERR: `error`=1, `cpu_rst_n`=0. Memory keeps the partially written data.
- In DONE or ERR, `SYNC_BYTE` starts a new frame: go to LEN and clear `done`/`error`. Other bytes are discarded.
- `N` > `DEPTH`: `word_idx` wraps modulo `DEPTH`. Writing past the end is not detected.

## Timing
- Reset values (while `rst_n`=0 at an edge, and for the following cycle):
  - state IDLE;
  - `rx_ready`=0 during reset, 1 in the first cycle after;
  - `mem_we`=0, `mem_addr`=0, `mem_wdata`=0;
  - `busy`=0, `done`=0, `error`=0;
  - `cpu_rst_n` = ~`BOOT_HOLD`.
- All outputs are registered or decoded from state only. No combinational path from `rx_*` to outputs.
- 4th byte accepted at edge k: `mem_we` is high for the cycle after edge k, with `rx_ready` low for that same cycle. At most one byte is accepted every cycle otherwise.
- `cpu_rst_n` falls in the cycle after the length byte is accepted.
- Checksum byte accepted at edge k: `done`/`error`, and `cpu_rst_n` (on success), change in the cycle after edge k.
- `rx_valid` gaps of any length are tolerated in every state. There is no timeout.
- Reset mid-frame: the partial word is discarded, no `mem_we` is issued, and all outputs return to reset values at the next edge.

## Test plan
- Reset, `BOOT_HOLD`=0 → `cpu_rst_n`=1, `rx_ready`=0 then 1, `mem_we`/`busy`/`done`/`error`=0, `mem_addr`=0.
- Send A5 02 93 00 A0 00 13 01 40 01 60 → `mem_we` pulses (addr 0x0, data 0x00A00093) and (addr 0x4, data 0x01400113); `rx_ready` low during each pulse; `cpu_rst_n` low from the cycle after the length byte; then `done`=1, `cpu_rst_n`=1.
- Same frame with checksum 0x61 → `error`=1, `done`=0, `cpu_rst_n`=0. Then resend the good frame → `error` clears, `done`=1, `cpu_rst_n`=1.
- Bytes 00 FF 5A in IDLE, plus a frame with random `rx_valid` gaps → noise ignored with no `mem_we`; frame writes correct; exactly one write per 4 data bytes.
- Length 0 with 1024 data bytes → 256 writes, last at addr 0x3FC, then CSUM; correct checksum gives `done`=1.
- `rst_n` low after 2 data bytes of word 0 → no write; `busy`=0 and `cpu_rst_n`=1 after reset. A full frame resent afterwards writes addr 0x0 with the correct word.
